// File: rtl/mp_cache_data_port.sv
// Drives the single RW port of the cache data SRAM from a valid/ready request stream; zero-fills every set after reset.
// Latency: the read is accepted at edge N and its response is visible after edge N+1. Writes produce no response.
// Backpressure: credits are shared between the 2-entry response buffer and the read in flight; req_ready drops when both credits are in use.
module mp_cache_data_port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WMASKS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_inflight;
  logic [1:0]            count;
  logic                  wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  accept, rd_accept, push, pop;
  logic [2:0]            credit_use;

  // Credit accounting: a slot freed by this cycle's pop can be reused by this cycle's accept.
  assign pop        = rsp_valid && rsp_ready;
  assign push       = rd_inflight;
  assign credit_use = {1'b0, count} + {2'b00, rd_inflight} - {2'b00, pop};
  assign req_ready  = !rst && (state == ST_RUN) && (credit_use < 3'd2);
  assign accept     = req_valid && req_ready;
  assign rd_accept  = accept && !req_write;
  assign rsp_valid  = !rst && (count != 2'd0);
  assign rsp_rdata  = fifo_mem[rd_ptr];

  // State register and sweep counter; reset restarts the zero-fill from set 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  // Next state and SRAM port drive; the port idles while reset is held.
  always_comb begin
    state_nxt  = state;
    init_done  = 1'b0;
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_wmask = '0;
    sram_addr  = '0;
    sram_din   = '0;
    if (!rst) begin
      case (state)
        ST_INIT: begin
          sram_csb   = 1'b0;
          sram_web   = 1'b0;
          sram_wmask = '1;
          sram_addr  = init_cnt;
          if (init_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          init_done = 1'b1;
          if (accept) begin
            if (!req_write) begin
              sram_csb  = 1'b0;
              sram_addr = req_addr;
            end else if (req_wmask != '0) begin
              // An all-zero mask write is consumed without touching the macro.
              sram_csb   = 1'b0;
              sram_web   = 1'b0;
              sram_wmask = req_wmask;
              sram_addr  = req_addr;
              sram_din   = req_wdata;
            end
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  // Read-in-flight flag: the macro's data is valid one cycle after the read issues.
  always_ff @(posedge clk) begin
    if (rst) rd_inflight <= 1'b0;
    else     rd_inflight <= rd_accept;
  end

  // Response buffer: captures macro output for in-flight reads, pops on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= sram_dout;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mp_cache_data_port.sv
// Directed bench for mp_cache_data_port with a behavioural model of the 16x256 SRAM macro.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_mp_cache_data_port;

  localparam int AW = 4;
  localparam int DW = 256;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [NW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb, sram_web;
  logic [NW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  logic [DW-1:0] ram [16];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] d_a5, d_part, d_11, d_22, d_ff3c;
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] exp_ord [3];
  logic [DW-1:0] thr_exp [6];
  logic [AW-1:0] thr_addr [6];
  logic [DW-1:0] got_v;

  always #5 clk = ~clk;

  mp_cache_data_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .sram_csb   (sram_csb),
    .sram_web   (sram_web),
    .sram_wmask (sram_wmask),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // SRAM macro model: masked byte writes, registered read data.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        for (int b = 0; b < NW; b++)
          if (sram_wmask[b]) ram[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      end else begin
        sram_dout <= ram[sram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wmask = '0;
    req_wdata = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [NW-1:0] m, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wmask = m; req_wdata = d;
    #1;
    check("wr_ready", req_ready, 1);
    if (m != '0) begin
      check("wr_csb", sram_csb, 0);
      check("wr_web", sram_web, 0);
      check("wr_mask", sram_wmask, m);
      check("wr_addr", sram_addr, a);
      check("wr_din", sram_din, d);
    end else begin
      check("wr0_csb", sram_csb, 1);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    #1;
    check("rd_ready", req_ready, 1);
    check("rd_csb", sram_csb, 0);
    check("rd_web", sram_web, 1);
    check("rd_mask", sram_wmask, 0);
    check("rd_addr", sram_addr, a);
    @(negedge clk);
    drive_idle();
  endtask

  // Called one cycle after the read accept edge: response must be present now.
  task automatic take_rsp(input string tag, input logic [DW-1:0] exp);
    #1;
    check({tag, "_vld"}, rsp_valid, 1);
    check({tag, "_dat"}, rsp_rdata, exp);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Called at the falling edge right after the reset edge, with rst just released.
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      #1;
      check({tag, "_csb"}, sram_csb, 0);
      check({tag, "_web"}, sram_web, 0);
      check({tag, "_addr"}, sram_addr, i);
      check({tag, "_mask"}, sram_wmask, {NW{1'b1}});
      check({tag, "_din"}, sram_din, 0);
      check({tag, "_done"}, init_done, 0);
      check({tag, "_rdy"}, req_ready, 0);
      @(negedge clk);
    end
    #1;
    check({tag, "_done_end"}, init_done, 1);
    check({tag, "_rdy_end"}, req_ready, 1);
    check({tag, "_csb_end"}, sram_csb, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    d_a5   = {32{8'hA5}};
    d_ff3c = {{31{8'hFF}}, 8'h3C};
    d_part = {{31{8'hA5}}, 8'h3C};
    d_11   = {32{8'h11}};
    d_22   = {32{8'h22}};
    for (int i = 0; i < 16; i++) ram[i] <= {8{32'hDEADBEEF}};
    drive_idle();
    rsp_ready = 1'b0;
    rst = 1'b1;

    // Reset values while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_rdy", req_ready, 0);
    check("rst_rvld", rsp_valid, 0);
    check("rst_rdat", rsp_rdata, 0);
    check("rst_done", init_done, 0);
    check("rst_csb", sram_csb, 1);
    check("rst_web", sram_web, 1);
    check("rst_mask", sram_wmask, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_din", sram_din, 0);
    rst = 1'b0;

    // Zero-fill sweep: 16 writes then RUN
    sweep_check("sweep");

    // Read of a zero-filled set, exact 1-cycle latency
    do_read(4'd5);
    #1 check("rd5_lat", rsp_valid, 0);
    @(negedge clk);
    take_rsp("rd5", '0);

    // Full write then read the next cycle
    do_write(4'd3, '1, d_a5);
    do_read(4'd3);
    #1 check("a5_lat", rsp_valid, 0);
    @(negedge clk);
    take_rsp("a5", d_a5);

    // Byte-masked write affects only byte 0
    do_write(4'd3, 32'h0000_0001, d_ff3c);
    do_read(4'd3);
    @(negedge clk);
    take_rsp("part", d_part);

    // Zero-mask write: no macro access, data unchanged
    do_write(4'd3, '0, '0);
    do_read(4'd3);
    @(negedge clk);
    take_rsp("mask0", d_part);

    // Backpressure: two reads accepted, third held off
    do_write(4'd1, '1, d_11);
    do_write(4'd2, '1, d_22);
    do_read(4'd1);
    do_read(4'd2);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
    #1 check("bp_rdy0", req_ready, 0);
    @(negedge clk);
    #1;
    check("bp_rdy1", req_ready, 0);
    check("bp_vld", rsp_valid, 1);
    check("bp_hold0", rsp_rdata, d_11);
    @(negedge clk);
    #1 check("bp_hold1", rsp_rdata, d_11);
    rsp_ready = 1'b1;
    #1 check("bp_rdy_pop", req_ready, 1);
    got_q.delete();
    if (rsp_valid) got_q.push_back(rsp_rdata);
    @(negedge clk);
    drive_idle();
    repeat (5) begin
      #1;
      if (rsp_valid) got_q.push_back(rsp_rdata);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    exp_ord[0] = d_11; exp_ord[1] = d_22; exp_ord[2] = d_part;
    check("ord_cnt", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      got_v = (i < got_q.size()) ? got_q[i] : 'x;
      check("ord_dat", got_v, exp_ord[i]);
    end

    // Streaming reads at full throughput
    thr_addr[0] = 4'd1; thr_addr[1] = 4'd2; thr_addr[2] = 4'd3;
    thr_addr[3] = 4'd1; thr_addr[4] = 4'd2; thr_addr[5] = 4'd3;
    thr_exp[0] = d_11; thr_exp[1] = d_22; thr_exp[2] = d_part;
    thr_exp[3] = d_11; thr_exp[4] = d_22; thr_exp[5] = d_part;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = thr_addr[i];
      end else begin
        drive_idle();
      end
      #1;
      if (i < 6) check("thr_rdy", req_ready, 1);
      if (i >= 2) begin
        check("thr_vld", rsp_valid, 1);
        check("thr_dat", rsp_rdata, thr_exp[i-2]);
      end else begin
        check("thr_vld0", rsp_valid, 0);
      end
      @(negedge clk);
    end
    #1 check("thr_empty", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Reset with a full credit load (one buffered, one in flight)
    do_read(4'd1);
    do_read(4'd2);
    #1 check("pre_rst_vld", rsp_valid, 1);
    rst = 1'b1;
    #1 check("in_rst_csb", sram_csb, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_vld", rsp_valid, 0);
    check("post_rst_rdy", req_ready, 0);
    check("post_rst_done", init_done, 0);
    for (int i = 0; i < 5; i++) begin
      #1 check("part_sweep_addr", sram_addr, i);
      @(negedge clk);
    end

    // Reset during the sweep restarts it from set 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sweep_check("resweep");
    check("resweep_vld", rsp_valid, 0);
    do_read(4'd3);
    @(negedge clk);
    take_rsp("rezero", '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
